// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants for the ARP receive parser and its peers.
// Holds the ethertypes, ARP header field values, the encoded operation
// codes reported to the ARP scheduler, and the broadcast MAC address.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IP  = 16'h0800;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [7:0]  ARP_HLEN_ETH  = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IP   = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ  = 16'h0001;
  localparam logic [15:0] ARP_OPER_RESP = 16'h0002;

  // Encoded operation reported on o_arp_operation
  localparam logic [1:0]  ARP_OP_NONE   = 2'd0;
  localparam logic [1:0]  ARP_OP_REQ    = 2'd1;
  localparam logic [1:0]  ARP_OP_RESP   = 2'd2;

  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for frame statistics.
// Ports: clk, rst_n (async active-low), inc (count enable), count (value,
// sticks at all-ones instead of wrapping).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Count register: increment on request unless already saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/eth_arp_rx.sv
// Receive-side ARP parser on the MAC 32-bit Avalon-ST receive interface.
// Filters frames by destination MAC, decodes ARP requests/replies aimed at
// this node and reports each accepted frame one cycle after its eop beat.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_self_mac/i_self_ip  own addresses (quasi-static)
//   i_target_ip           peer IP; replies only accepted from it
//   i_data/i_vld/i_sop/i_eop, o_rdy   Avalon-ST sink (never back-pressures)
//   o_arp_operation       one-cycle pulse: 0 none, 1 request, 2 reply
//   o_arp_target_mac/ip   SHA/SPA of the last accepted frame
//   o_frame_cnt/o_drop_cnt  saturating accept/drop counters
//   o_led                 [0] req toggle, [1] reply toggle, [2] drop toggle, [3] busy
module eth_arp_rx
  import eth_pkg::*;
#(
  parameter logic BCAST_EN = 1'b1,
  parameter int   CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [47:0]      i_self_mac,
  input  logic [31:0]      i_self_ip,
  input  logic [31:0]      i_target_ip,
  input  logic [31:0]      i_data,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic             i_sop,
  input  logic             i_eop,
  output logic [1:0]       o_arp_operation,
  output logic [47:0]      o_arp_target_mac,
  output logic [31:0]      o_arp_target_ip,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic [3:0]       o_led
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PARSE = 2'd1,
    ST_TAIL  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  state_e      state_r, state_n;
  logic [3:0]  wcnt_r, wcnt_n;
  logic [3:0]  idx_s;
  logic        beat_s, field_ok_s, accept_s, drop_s;
  logic [1:0]  op_s;
  logic        rdy_r;
  logic        self_hi_r, bc_hi_r;
  logic [15:0] oper_r;
  logic [47:0] sha_r;
  logic [31:0] spa_r;
  logic [1:0]  op_r;
  logic [47:0] mac_r;
  logic [31:0] ip_r;
  logic [3:0]  led_r;

  assign beat_s = i_vld && rdy_r;
  // A sop beat always restarts parsing at word 0, whatever the state
  assign idx_s  = i_sop ? 4'd0 : wcnt_r;
  assign op_s   = (oper_r == ARP_OPER_REQ) ? ARP_OP_REQ : ARP_OP_RESP;

  // Field check for the word currently on i_data
  always_comb begin
    field_ok_s = 1'b0;
    case (idx_s)
      4'd0: field_ok_s = (i_data == i_self_mac[47:16]) ||
                         (BCAST_EN && (i_data == BCAST_MAC[47:16]));
      4'd1: field_ok_s = (self_hi_r && (i_data[31:16] == i_self_mac[15:0])) ||
                         (BCAST_EN && bc_hi_r && (i_data[31:16] == BCAST_MAC[15:0]));
      4'd2: field_ok_s = 1'b1;
      4'd3: field_ok_s = (i_data == {ETHERTYPE_ARP, ARP_HTYPE_ETH});
      4'd4: field_ok_s = (i_data == {ETHERTYPE_IP, ARP_HLEN_ETH, ARP_PLEN_IP});
      4'd5: field_ok_s = (i_data[31:16] == ARP_OPER_REQ) || (i_data[31:16] == ARP_OPER_RESP);
      4'd6: field_ok_s = 1'b1;
      // Requests come from anyone; replies only from the peer we asked
      4'd7: field_ok_s = (oper_r == ARP_OPER_REQ) || (i_data == i_target_ip);
      4'd8: field_ok_s = 1'b1;
      4'd9: field_ok_s = (i_data[15:0] == i_self_ip[31:16]);
      4'd10: field_ok_s = (i_data[31:16] == i_self_ip[15:0]);
      default: field_ok_s = 1'b0;
    endcase
  end

  // Next-state, beat counter and completion decisions
  always_comb begin
    state_n  = state_r;
    wcnt_n   = wcnt_r;
    accept_s = 1'b0;
    drop_s   = 1'b0;
    if (beat_s) begin
      if (i_sop) begin
        // Abandon any frame in flight; sop+eop is a runt
        drop_s = (state_r != ST_IDLE) || i_eop;
        wcnt_n = 4'd1;
        if (i_eop) begin
          state_n = ST_IDLE;
        end else if (field_ok_s) begin
          state_n = ST_PARSE;
        end else begin
          state_n = ST_DROP;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_n = ST_IDLE;
          end
          ST_PARSE: begin
            wcnt_n = (wcnt_r == 4'hF) ? wcnt_r : (wcnt_r + 4'd1);
            if (!field_ok_s) begin
              drop_s  = i_eop;
              state_n = i_eop ? ST_IDLE : ST_DROP;
            end else if (wcnt_r == 4'd10) begin
              accept_s = i_eop;
              state_n  = i_eop ? ST_IDLE : ST_TAIL;
            end else begin
              drop_s  = i_eop;
              state_n = i_eop ? ST_IDLE : ST_PARSE;
            end
          end
          ST_TAIL: begin
            wcnt_n   = (wcnt_r == 4'hF) ? wcnt_r : (wcnt_r + 4'd1);
            accept_s = i_eop;
            state_n  = i_eop ? ST_IDLE : ST_TAIL;
          end
          ST_DROP: begin
            wcnt_n  = (wcnt_r == 4'hF) ? wcnt_r : (wcnt_r + 4'd1);
            drop_s  = i_eop;
            state_n = i_eop ? ST_IDLE : ST_DROP;
          end
          default: begin
            state_n = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_n = state_r;
    end
  end

  // State, beat counter and ready register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      wcnt_r  <= 4'd0;
      rdy_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      wcnt_r  <= wcnt_n;
      rdy_r   <= 1'b1;
    end
  end

  // Shadow capture of destination-match flags, OPER, SHA and SPA while parsing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      self_hi_r <= 1'b0;
      bc_hi_r   <= 1'b0;
      oper_r    <= 16'h0000;
      sha_r     <= 48'h0;
      spa_r     <= 32'h0;
    end else if (beat_s && (i_sop || (state_r == ST_PARSE))) begin
      case (idx_s)
        4'd0: begin
          self_hi_r <= (i_data == i_self_mac[47:16]);
          bc_hi_r   <= (i_data == BCAST_MAC[47:16]);
        end
        4'd5: begin
          oper_r        <= i_data[31:16];
          sha_r[47:32]  <= i_data[15:0];
        end
        4'd6: sha_r[31:0] <= i_data;
        4'd7: spa_r       <= i_data;
        default: spa_r    <= spa_r;
      endcase
    end
  end

  // Result pulse, last-accepted addresses and debug LEDs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= ARP_OP_NONE;
      mac_r <= 48'h0;
      ip_r  <= 32'h0;
      led_r <= 4'h0;
    end else begin
      op_r     <= accept_s ? op_s : ARP_OP_NONE;
      if (accept_s) begin
        mac_r <= sha_r;
        ip_r  <= spa_r;
      end
      led_r[0] <= led_r[0] ^ (accept_s && (op_s == ARP_OP_REQ));
      led_r[1] <= led_r[1] ^ (accept_s && (op_s == ARP_OP_RESP));
      led_r[2] <= led_r[2] ^ drop_s;
      led_r[3] <= (state_n != ST_IDLE);
    end
  end

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_s),
    .count (o_frame_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_s),
    .count (o_drop_cnt)
  );

  assign o_rdy            = rdy_r;
  assign o_arp_operation  = op_r;
  assign o_arp_target_mac = mac_r;
  assign o_arp_target_ip  = ip_r;
  assign o_led            = led_r;

endmodule

// File: tb/tb_eth_arp_rx.sv
// Directed bench for eth_arp_rx: builds ARP/Ethernet frames word by word,
// queues the expected result pulse (with its cycle) on a scoreboard when the
// eop beat is driven, and a monitor pops and compares whenever a pulse shows.
module tb_eth_arp_rx;

  localparam logic [47:0] SELF_MAC = 48'h00_23_54_3C_47_1B;
  localparam logic [31:0] SELF_IP  = 32'h0A00_000B;
  localparam logic [31:0] PEER_IP  = 32'h0A00_006F;
  localparam logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC_MAC   = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = 32'h0;
  logic        vld = 1'b0, sop = 1'b0, eop = 1'b0;
  logic        rdy;
  logic [1:0]  op;
  logic [47:0] tmac;
  logic [31:0] tip;
  logic [15:0] frame_cnt, drop_cnt;
  logic [3:0]  led;

  typedef struct {
    logic [1:0]  op;
    logic [47:0] mac;
    logic [31:0] ip;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] frame[0:15];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  eth_arp_rx #(.BCAST_EN(1'b1), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_self_mac       (SELF_MAC),
    .i_self_ip        (SELF_IP),
    .i_target_ip      (PEER_IP),
    .i_data           (data),
    .i_vld            (vld),
    .o_rdy            (rdy),
    .i_sop            (sop),
    .i_eop            (eop),
    .o_arp_operation  (op),
    .o_arp_target_mac (tmac),
    .o_arp_target_ip  (tip),
    .o_frame_cnt      (frame_cnt),
    .o_drop_cnt       (drop_cnt),
    .o_led            (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard, on time
  always @(negedge clk) begin
    if (op !== 2'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'(op), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_op", 64'(op), 64'(e.op));
        chk("pulse_mac", 64'(tmac), 64'(e.mac));
        chk("pulse_ip", 64'(tip), 64'(e.ip));
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic build(input logic [47:0] dst, input logic [15:0] etype,
                       input logic [15:0] oper, input logic [47:0] sha,
                       input logic [31:0] spa, input logic [31:0] tpa);
    frame[0]  = dst[47:16];
    frame[1]  = {dst[15:0], SRC_MAC[47:32]};
    frame[2]  = SRC_MAC[31:0];
    frame[3]  = {etype, 16'h0001};
    frame[4]  = {16'h0800, 8'd6, 8'd4};
    frame[5]  = {oper, sha[47:32]};
    frame[6]  = sha[31:0];
    frame[7]  = spa;
    frame[8]  = 32'h0;
    frame[9]  = {16'h0000, tpa[31:16]};
    frame[10] = {tpa[15:0], 16'h0000};
    for (int i = 11; i < 16; i++) frame[i] = 32'h0;
  endtask

  // Drive words first..last; sop on word 0, eop on last when with_eop.
  // A nonzero exp_op queues the expected pulse one cycle after the eop edge.
  task automatic send(input int first, input int last, input bit toggle,
                      input bit with_eop, input logic [1:0] exp_op,
                      input logic [47:0] emac, input logic [31:0] eip);
    for (int i = first; i <= last; i++) begin
      if (toggle && i != first) begin
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
        @(posedge clk); #1;
      end
      data = frame[i];
      vld  = 1'b1;
      sop  = (i == 0);
      eop  = with_eop && (i == last);
      if (eop && exp_op != 2'd0) sb.push_back('{exp_op, emac, eip, cyc + 1});
      @(posedge clk); #1;
    end
    vld = 1'b0; sop = 1'b0; eop = 1'b0; data = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_rdy", 64'(rdy), 64'd0);
    chk("reset_op", 64'(op), 64'd0);
    chk("reset_mac", 64'(tmac), 64'd0);
    chk("reset_ip", 64'(tip), 64'd0);
    chk("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset_led", 64'(led), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_reset", 64'(rdy), 64'd1);

    // Broadcast request, padded to 15 beats
    build(BC_MAC, 16'h0806, 16'd1, 48'h00_11_22_33_44_55, 32'h0A00_006F, SELF_IP);
    send(0, 14, 1'b0, 1'b1, 2'd1, 48'h00_11_22_33_44_55, 32'h0A00_006F);
    chk("req_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("req_mac", 64'(tmac), 64'h0011_2233_4455);
    chk("req_ip", 64'(tip), 64'h0A00_006F);
    chk("req_led0", 64'(led[0]), 64'd1);

    // Unicast reply from the peer with valid toggling every other cycle
    build(SELF_MAC, 16'h0806, 16'd2, 48'h66_77_88_99_AA_BB, PEER_IP, SELF_IP);
    send(0, 11, 1'b1, 1'b1, 2'd2, 48'h66_77_88_99_AA_BB, PEER_IP);
    chk("rep_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rep_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("rep_led1", 64'(led[1]), 64'd1);

    // Reply from wrong SPA, request to a foreign TPA: both dropped
    build(SELF_MAC, 16'h0806, 16'd2, 48'h12_34_56_78_9A_BC, 32'h0A00_0005, SELF_IP);
    send(0, 14, 1'b0, 1'b1, 2'd0, 48'h0, 32'h0);
    build(BC_MAC, 16'h0806, 16'd1, 48'h12_34_56_78_9A_BC, 32'h0A00_0006, 32'h0A00_000C);
    send(0, 14, 1'b0, 1'b1, 2'd0, 48'h0, 32'h0);
    chk("filt_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("filt_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("filt_mac_held", 64'(tmac), 64'h6677_8899_AABB);
    chk("filt_ip_held", 64'(tip), 64'(PEER_IP));

    // IPv4 ethertype frame, then a runt ARP ending at word 5
    build(SELF_MAC, 16'h0800, 16'd1, 48'h00_11_22_33_44_55, PEER_IP, SELF_IP);
    send(0, 14, 1'b0, 1'b1, 2'd0, 48'h0, 32'h0);
    build(SELF_MAC, 16'h0806, 16'd1, 48'h00_11_22_33_44_55, PEER_IP, SELF_IP);
    send(0, 5, 1'b0, 1'b1, 2'd0, 48'h0, 32'h0);
    chk("runt_drop_cnt", 64'(drop_cnt), 64'd4);
    chk("runt_led2", 64'(led[2]), 64'd0);

    // sop interrupts a valid request at beat 7, then a full valid reply
    build(BC_MAC, 16'h0806, 16'd1, 48'h00_11_22_33_44_55, PEER_IP, SELF_IP);
    send(0, 6, 1'b0, 1'b0, 2'd0, 48'h0, 32'h0);
    chk("abort_busy", 64'(led[3]), 64'd1);
    build(SELF_MAC, 16'h0806, 16'd2, 48'hAA_BB_CC_DD_EE_01, PEER_IP, SELF_IP);
    send(0, 14, 1'b0, 1'b1, 2'd2, 48'hAA_BB_CC_DD_EE_01, PEER_IP);
    chk("abort_drop_cnt", 64'(drop_cnt), 64'd5);
    chk("abort_frame_cnt", 64'(frame_cnt), 64'd3);

    // Reset mid-frame at beat 8, then the tail arrives without sop
    build(BC_MAC, 16'h0806, 16'd1, 48'h00_11_22_33_44_55, PEER_IP, SELF_IP);
    send(0, 7, 1'b0, 1'b0, 2'd0, 48'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 64'(rdy), 64'd0);
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8, 14, 1'b0, 1'b1, 2'd0, 48'h0, 32'h0);
    chk("tail_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("tail_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("tail_mac", 64'(tmac), 64'd0);
    chk("tail_ip", 64'(tip), 64'd0);
    chk("tail_led", 64'(led), 64'd0);
    chk("tail_rdy", 64'(rdy), 64'd1);

    @(posedge clk); #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
